// File: rtl/ge_dbl_n_pkg.sv
// Shared types for the repeated point-doubling block (ge_dbl_n).
// Provides field-element width, point structs, FSM state enums and the
// fixed latencies of the sequential field units.
package ge_pkg;

  localparam int unsigned FE_W  = 320;  // 10 x 32-bit signed limbs
  localparam int unsigned CNT_W = 4;    // doubling count width

  // Latency (WAIT cycles up to and including done) of the sequential units
  localparam int unsigned LAT_SQ  = 4;
  localparam int unsigned LAT_SQ2 = 3;
  localparam int unsigned LAT_MUL = 5;

  typedef logic signed [FE_W-1:0] fe_t;

  typedef struct packed {
    fe_t x;
    fe_t y;
    fe_t z;
  } ge_p2_t;

  typedef struct packed {
    fe_t x;
    fe_t y;
    fe_t z;
    fe_t t;
  } ge_p1p1_t;

  typedef enum logic [4:0] {
    ST_IDLE, ST_XX_S, ST_XX_W, ST_YY_S, ST_YY_W, ST_B_S, ST_B_W, ST_A,
    ST_AA_S, ST_AA_W, ST_RYZ, ST_RX, ST_RT, ST_CHK, ST_CONV_S, ST_CONV_W,
    ST_OUT
  } dbl_state_e;

  typedef enum logic [2:0] {
    CV_IDLE, CV_MX_W, CV_MY_S, CV_MY_W, CV_MZ_S, CV_MZ_W
  } conv_state_e;

endpackage

// File: rtl/ge_dbl_n_fe.sv
// Field-element arithmetic units used by ge_dbl_n.
// fe_add / fe_sub : combinational a+b / a-b  (a_i, b_i -> res_c)
// fe_sq / fe_sq2 / fe_mul : start/done units (clk, rst_n, start_i, a_i[, b_i]
//   -> res_o, done_o); result captured on start, done_o pulses LAT cycles later.
// Arithmetic is plain integer arithmetic on the packed vector, truncated to FE_W.

// Shared start/done timing core; LAT must be >= 2.
module fe_seq_core
  import ge_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  fe_t  val_i,
  output fe_t  res_o,
  output logic done_o
);
  localparam int unsigned CW = $clog2(LAT + 1);

  logic [CW-1:0] cnt_q;
  fe_t           res_q;
  logic          done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        cnt_q <= CW'(LAT - 1);
        res_q <= val_i;
      end else if (cnt_q != '0) begin
        cnt_q  <= cnt_q - CW'(1);
        done_q <= (cnt_q == CW'(1));
      end
    end
  end

  assign res_o  = res_q;
  assign done_o = done_q;
endmodule

module fe_add
  import ge_pkg::*;
(
  input  fe_t a_i,
  input  fe_t b_i,
  output fe_t res_c
);
  assign res_c = a_i + b_i;
endmodule

module fe_sub
  import ge_pkg::*;
(
  input  fe_t a_i,
  input  fe_t b_i,
  output fe_t res_c
);
  assign res_c = a_i - b_i;
endmodule

module fe_sq
  import ge_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  fe_t  a_i,
  output fe_t  res_o,
  output logic done_o
);
  fe_t sq_c;
  assign sq_c = a_i * a_i;
  fe_seq_core #(.LAT(LAT_SQ)) u_core (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .val_i(sq_c),
    .res_o(res_o), .done_o(done_o)
  );
endmodule

module fe_sq2
  import ge_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  fe_t  a_i,
  output fe_t  res_o,
  output logic done_o
);
  fe_t sq_c;
  fe_t dbl_c;
  assign sq_c  = a_i * a_i;
  assign dbl_c = sq_c + sq_c;
  fe_seq_core #(.LAT(LAT_SQ2)) u_core (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .val_i(dbl_c),
    .res_o(res_o), .done_o(done_o)
  );
endmodule

module fe_mul
  import ge_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  fe_t  a_i,
  input  fe_t  b_i,
  output fe_t  res_o,
  output logic done_o
);
  fe_t prod_c;
  assign prod_c = a_i * b_i;
  fe_seq_core #(.LAT(LAT_MUL)) u_core (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .val_i(prod_c),
    .res_o(res_o), .done_o(done_o)
  );
endmodule

// File: rtl/ge_dbl_n_p1p1_to_p2.sv
// ge_p1p1 -> ge_p2 conversion on one shared fe_mul: X=rX*rT, Y=rY*rZ, Z=rZ*rT.
// Ports: clk, rst_n (async active-low), start_i (one-cycle pulse, starts MX in
// the same cycle), r_i (p1p1 operands, held stable by the caller),
// p2_o (result, valid with done_c), done_c (one-cycle completion strobe).
module ge_p1p1_to_p2
  import ge_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     start_i,
  input  ge_p1p1_t r_i,
  output ge_p2_t   p2_o,
  output logic     done_c
);
  conv_state_e state_q, state_d;
  fe_t         x_q, x_d, y_q, y_d;
  fe_t         mul_a_c, mul_b_c, mul_res;
  logic        mul_start_c, mul_done;

  fe_mul u_mul (
    .clk(clk), .rst_n(rst_n), .start_i(mul_start_c), .a_i(mul_a_c),
    .b_i(mul_b_c), .res_o(mul_res), .done_o(mul_done)
  );

  // MX start is taken straight from start_i so conversion costs 3 + sum(W)
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    mul_start_c = 1'b0;
    mul_a_c     = r_i.x;
    mul_b_c     = r_i.t;
    done_c      = 1'b0;
    unique case (state_q)
      CV_IDLE: if (start_i) begin
        mul_start_c = 1'b1;
        state_d     = CV_MX_W;
      end
      CV_MX_W: if (mul_done) begin
        x_d     = mul_res;
        state_d = CV_MY_S;
      end
      CV_MY_S: begin
        mul_a_c     = r_i.y;
        mul_b_c     = r_i.z;
        mul_start_c = 1'b1;
        state_d     = CV_MY_W;
      end
      CV_MY_W: begin
        mul_a_c = r_i.y;
        mul_b_c = r_i.z;
        if (mul_done) begin
          y_d     = mul_res;
          state_d = CV_MZ_S;
        end
      end
      CV_MZ_S: begin
        mul_a_c     = r_i.z;
        mul_b_c     = r_i.t;
        mul_start_c = 1'b1;
        state_d     = CV_MZ_W;
      end
      CV_MZ_W: begin
        mul_a_c = r_i.z;
        mul_b_c = r_i.t;
        if (mul_done) begin
          done_c  = 1'b1;
          state_d = CV_IDLE;
        end
      end
      default: state_d = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CV_IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Z is read directly from the multiplier's result register
  assign p2_o = '{x: x_q, y: y_q, z: mul_res};
endmodule

// File: rtl/ge_dbl_n.sv
// Repeated ED25519 point doubling: returns 2^k * P in ge_p1p1 form.
// Ports: clk, reset (async active-high), in_valid/in_ready + in_X/Y/Z/in_cnt
// (request), out_valid/out_ready + out_X/Y/Z/T (result), busy (not idle).
// Macro GE_DBL_N_PARALLEL_SQ_EN: start fe_sq2 (B) alongside fe_sq (XX).
module ge_dbl_n
  import ge_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  fe_t              in_X,
  input  fe_t              in_Y,
  input  fe_t              in_Z,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output fe_t              out_X,
  output fe_t              out_Y,
  output fe_t              out_Z,
  output fe_t              out_T,
  output logic             busy
);
  dbl_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  ge_p2_t           p_q, p_d;
  fe_t              xx_q, xx_d, yy_q, yy_d, b_q, b_d, a_q, a_d, aa_q, aa_d;
  ge_p1p1_t         r_q, r_d, out_q, out_d;
  logic             in_ready_q, out_valid_q, busy_q;
`ifdef GE_DBL_N_PARALLEL_SQ_EN
  logic             xx_seen_q, xx_seen_d, b_seen_q, b_seen_d;
`endif

  logic   rst_n;
  logic   sq_start_c, sq2_start_c, conv_start_c, sq_done, sq2_done, conv_done;
  fe_t    sq_a_c, sq_res, sq2_res;
  fe_t    add_a_c, add_b_c, add_res, sub_a_c, sub_b_c, sub_res;
  ge_p2_t conv_p2;

  assign rst_n = ~reset;

  fe_sq  u_sq  (.clk(clk), .rst_n(rst_n), .start_i(sq_start_c), .a_i(sq_a_c),
                .res_o(sq_res), .done_o(sq_done));
  fe_sq2 u_sq2 (.clk(clk), .rst_n(rst_n), .start_i(sq2_start_c), .a_i(p_q.z),
                .res_o(sq2_res), .done_o(sq2_done));
  fe_add u_add (.a_i(add_a_c), .b_i(add_b_c), .res_c(add_res));
  fe_sub u_sub (.a_i(sub_a_c), .b_i(sub_b_c), .res_c(sub_res));
  ge_p1p1_to_p2 u_conv (.clk(clk), .rst_n(rst_n), .start_i(conv_start_c),
                        .r_i(r_q), .p2_o(conv_p2), .done_c(conv_done));

  // Next-state, datapath muxing and sub-unit control
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    p_d          = p_q;
    xx_d         = xx_q;
    yy_d         = yy_q;
    b_d          = b_q;
    a_d          = a_q;
    aa_d         = aa_q;
    r_d          = r_q;
    out_d        = out_q;
    sq_start_c   = 1'b0;
    sq2_start_c  = 1'b0;
    conv_start_c = 1'b0;
    sq_a_c       = '0;
    add_a_c      = '0;
    add_b_c      = '0;
    sub_a_c      = '0;
    sub_b_c      = '0;
`ifdef GE_DBL_N_PARALLEL_SQ_EN
    xx_seen_d    = xx_seen_q;
    b_seen_d     = b_seen_q;
`endif
    unique case (state_q)
      ST_IDLE: if (in_valid && in_ready_q) begin
        p_d   = '{x: in_X, y: in_Y, z: in_Z};
        rem_d = in_cnt;
        if (in_cnt == '0) begin
          out_d   = '{x: in_X, y: in_Y, z: in_Z, t: in_Z};
          state_d = ST_OUT;
        end else begin
          state_d = ST_XX_S;
        end
      end
      ST_XX_S: begin
        sq_a_c     = p_q.x;
        sq_start_c = 1'b1;
`ifdef GE_DBL_N_PARALLEL_SQ_EN
        sq2_start_c = 1'b1;
`endif
        state_d    = ST_XX_W;
      end
`ifdef GE_DBL_N_PARALLEL_SQ_EN
      // Both dones are latched since they may arrive in different cycles
      ST_XX_W: begin
        sq_a_c = p_q.x;
        if (sq_done) begin
          xx_d      = sq_res;
          xx_seen_d = 1'b1;
        end
        if (sq2_done) begin
          b_d      = sq2_res;
          b_seen_d = 1'b1;
        end
        if ((xx_seen_q || sq_done) && (b_seen_q || sq2_done)) begin
          xx_seen_d = 1'b0;
          b_seen_d  = 1'b0;
          state_d   = ST_YY_S;
        end
      end
`else
      ST_XX_W: begin
        sq_a_c = p_q.x;
        if (sq_done) begin
          xx_d    = sq_res;
          state_d = ST_YY_S;
        end
      end
`endif
      ST_YY_S: begin
        sq_a_c     = p_q.y;
        sq_start_c = 1'b1;
        state_d    = ST_YY_W;
      end
      ST_YY_W: begin
        sq_a_c = p_q.y;
        if (sq_done) begin
          yy_d = sq_res;
`ifdef GE_DBL_N_PARALLEL_SQ_EN
          state_d = ST_A;
`else
          state_d = ST_B_S;
`endif
        end
      end
      ST_B_S: begin
        sq2_start_c = 1'b1;
        state_d     = ST_B_W;
      end
      ST_B_W: if (sq2_done) begin
        b_d     = sq2_res;
        state_d = ST_A;
      end
      ST_A: begin
        add_a_c = p_q.x;
        add_b_c = p_q.y;
        a_d     = add_res;
        state_d = ST_AA_S;
      end
      ST_AA_S: begin
        sq_a_c     = a_q;
        sq_start_c = 1'b1;
        state_d    = ST_AA_W;
      end
      ST_AA_W: begin
        sq_a_c = a_q;
        if (sq_done) begin
          aa_d    = sq_res;
          state_d = ST_RYZ;
        end
      end
      ST_RYZ: begin
        add_a_c = yy_q;
        add_b_c = xx_q;
        sub_a_c = yy_q;
        sub_b_c = xx_q;
        r_d.y   = add_res;
        r_d.z   = sub_res;
        state_d = ST_RX;
      end
      ST_RX: begin
        sub_a_c = aa_q;
        sub_b_c = r_q.y;
        r_d.x   = sub_res;
        state_d = ST_RT;
      end
      ST_RT: begin
        sub_a_c = b_q;
        sub_b_c = r_q.z;
        r_d.t   = sub_res;
        state_d = ST_CHK;
      end
      ST_CHK: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          out_d   = r_q;
          state_d = ST_OUT;
        end else begin
          state_d = ST_CONV_S;
        end
      end
      ST_CONV_S: begin
        conv_start_c = 1'b1;
        state_d      = ST_CONV_W;
      end
      ST_CONV_W: if (conv_done) begin
        p_d     = conv_p2;
        state_d = ST_XX_S;
      end
      ST_OUT: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      p_q         <= '0;
      xx_q        <= '0;
      yy_q        <= '0;
      b_q         <= '0;
      a_q         <= '0;
      aa_q        <= '0;
      r_q         <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef GE_DBL_N_PARALLEL_SQ_EN
      xx_seen_q   <= 1'b0;
      b_seen_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      p_q         <= p_d;
      xx_q        <= xx_d;
      yy_q        <= yy_d;
      b_q         <= b_d;
      a_q         <= a_d;
      aa_q        <= aa_d;
      r_q         <= r_d;
      out_q       <= out_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_OUT);
      busy_q      <= (state_d != ST_IDLE);
`ifdef GE_DBL_N_PARALLEL_SQ_EN
      xx_seen_q   <= xx_seen_d;
      b_seen_q    <= b_seen_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_X     = out_q.x;
  assign out_Y     = out_q.y;
  assign out_Z     = out_q.z;
  assign out_T     = out_q.t;
endmodule

// File: tb/tb_ge_dbl_n.sv
// Directed bench for ge_dbl_n: hand-computed doubling results and latencies.
module tb_ge_dbl_n;
  import ge_pkg::*;

  localparam int W_SQ    = 4;
  localparam int W_SQ2   = 3;
  localparam int W_MUL   = 5;
  // XX,YY,B,AA starts + their waits + A,RYZ,RX,RT + CHK
  localparam int DBL_SEQ = 4 + 3 * W_SQ + W_SQ2 + 5;
`ifdef GE_DBL_N_PARALLEL_SQ_EN
  localparam int DBL     = DBL_SEQ - (1 + W_SQ2);
`else
  localparam int DBL     = DBL_SEQ;
`endif
  localparam int CONV    = 3 + 3 * W_MUL;
  localparam int LAT_LIMIT = 2000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  fe_t              in_X = '0, in_Y = '0, in_Z = '0;
  logic [CNT_W-1:0] in_cnt = '0;
  logic             in_ready, out_valid, busy;
  fe_t              out_X, out_Y, out_Z, out_T;

  int errors = 0;
  int checks = 0;

  ge_dbl_n dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_X(in_X), .in_Y(in_Y), .in_Z(in_Z), .in_cnt(in_cnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_X(out_X), .out_Y(out_Y), .out_Z(out_Z), .out_T(out_T), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input int k);
    return (k == 0) ? 1 : k * DBL + (k - 1) * CONV + 1;
  endfunction

  task automatic check(input string tag, input fe_t obs, input fe_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request and count edges (accept edge = 1) until out_valid
  task automatic run(input fe_t x, input fe_t y, input fe_t z, input int k,
                     output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_X = x; in_Y = y; in_Z = z; in_cnt = CNT_W'(k); in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < LAT_LIMIT) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input fe_t x, input fe_t y,
                            input fe_t z, input fe_t t, input int k,
                            input int lat);
    check({tag, ".lat"}, fe_t'(lat), fe_t'(exp_lat(k)));
    check({tag, ".valid"}, fe_t'(out_valid), fe_t'(1));
    check({tag, ".X"}, out_X, x);
    check({tag, ".Y"}, out_Y, y);
    check({tag, ".Z"}, out_Z, z);
    check({tag, ".T"}, out_T, t);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".hs_valid"}, fe_t'(out_valid), fe_t'(0));
    check({tag, ".hs_ready"}, fe_t'(in_ready), fe_t'(1));
  endtask

  initial begin
    int lat;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", fe_t'(in_ready), fe_t'(0));
    check("rst.out_valid", fe_t'(out_valid), fe_t'(0));
    check("rst.busy", fe_t'(busy), fe_t'(0));
    check("rst.X", out_X, 0);
    check("rst.T", out_T, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel.in_ready", fe_t'(in_ready), fe_t'(1));

    // k=0 passes the point through with T=Z
    run(5, 7, 3, 0, lat);
    expect_out("p_k0", 5, 7, 3, 3, 0, lat);
    handshake("p_k0");

    // Identity, one doubling
    run(0, 1, 1, 1, lat);
    expect_out("id_k1", 0, 1, 1, 1, 1, lat);
    handshake("id_k1");

    // (5,7,3): XX=25 YY=49 B=18 A=12 AA=144
    run(5, 7, 3, 1, lat);
    expect_out("p_k1", 70, 74, 24, -6, 1, lat);
    handshake("p_k1");

    // Second doubling from (-420, 1776, -144)
    run(5, 7, 3, 2, lat);
    expect_out("p_k2", -1491840, 3330576, 2977776, -2936304, 2, lat);

    // Stalled consumer: outputs hold, stray in_valid pulse ignored
    in_X = 9; in_Y = 9; in_Z = 9; in_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      @(posedge clk); #1;
      check("stall.valid", fe_t'(out_valid), fe_t'(1));
      check("stall.ready", fe_t'(in_ready), fe_t'(0));
      check("stall.X", out_X, -1491840);
      check("stall.T", out_T, -2936304);
    end

    // Handshake with a new request pending: taken only after IDLE
    in_X = 0; in_Y = 1; in_Z = 1; in_cnt = '0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ovl.valid", fe_t'(out_valid), fe_t'(0));
    check("ovl.busy", fe_t'(busy), fe_t'(0));
    check("ovl.ready", fe_t'(in_ready), fe_t'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("ovl_k0", 0, 1, 1, 1, 0, 1);
    handshake("ovl_k0");

    // Maximum count on the identity
    run(0, 1, 1, 15, lat);
    expect_out("id_k15", 0, 1, 1, 1, 15, lat);
    handshake("id_k15");

    // Reset during the second multiply of the first conversion
    in_X = 5; in_Y = 7; in_Z = 3; in_cnt = CNT_W'(2); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (DBL + 3 + W_MUL) @(posedge clk);
    #1;
    check("mid.busy", fe_t'(busy), fe_t'(1));
    reset = 1'b1;
    #1;
    check("arst.busy", fe_t'(busy), fe_t'(0));
    check("arst.ready", fe_t'(in_ready), fe_t'(0));
    check("arst.valid", fe_t'(out_valid), fe_t'(0));
    check("arst.X", out_X, 0);
    check("arst.Y", out_Y, 0);
    check("arst.Z", out_Z, 0);
    check("arst.T", out_T, 0);
    @(posedge clk); #1;
    check("arst.ready_hold", fe_t'(in_ready), fe_t'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    check("arst.ready_rel", fe_t'(in_ready), fe_t'(1));

    run(5, 7, 3, 1, lat);
    expect_out("post_rst_k1", 70, 74, 24, -6, 1, lat);
    handshake("post_rst_k1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
